// File: rtl/alu_mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the ALU-function decoder.
package alu_mul_div_pkg;

    localparam int unsigned ALU_MD_WIDTH = 32;
    localparam int unsigned ALU_MD_CNT_W = 6;

    typedef enum logic [4:0] {
        Alu_Func_Add  = 5'h00,
        Alu_Func_Sub  = 5'h01,
        Alu_Func_And  = 5'h02,
        Alu_Func_Or   = 5'h03,
        Alu_Func_Xor  = 5'h04,
        Alu_Func_Slt  = 5'h05,
        Alu_Func_Muls = 5'h10,
        Alu_Func_Mulu = 5'h11,
        Alu_Func_Divs = 5'h12,
        Alu_Func_Divu = 5'h13,
        Alu_Func_Mfhi = 5'h14,
        Alu_Func_Mflo = 5'h15,
        Alu_Func_Mthi = 5'h16,
        Alu_Func_Mtlo = 5'h17
    } Alu_Func_T;

    typedef enum logic [1:0] {
        Alu_MulDiv_State_Idle = 2'd0,
        Alu_MulDiv_State_Run  = 2'd1,
        Alu_MulDiv_State_Fix  = 2'd2
    } Alu_MulDiv_State_T;

    // Latched description of the in-flight mul/div op.
    typedef struct packed {
        logic is_div;
        logic is_signed;
        logic a_neg;
        logic b_neg;
    } Alu_MulDiv_Op_T;

    // Quotient reported for any divide by zero.
    localparam logic [ALU_MD_WIDTH-1:0] ALU_MD_DIV0_QUOTIENT = '1;

    function automatic logic is_muldiv_op(input Alu_Func_T f);
        return f inside {Alu_Func_Muls, Alu_Func_Mulu, Alu_Func_Divs, Alu_Func_Divu};
    endfunction

    function automatic logic is_hilo_op(input Alu_Func_T f);
        return is_muldiv_op(f) ||
               (f inside {Alu_Func_Mfhi, Alu_Func_Mflo, Alu_Func_Mthi, Alu_Func_Mtlo});
    endfunction

endpackage

// File: rtl/alu_mul_div_if.sv
// Execute-stage to mul/div unit handshake and HI/LO read-back.
interface alu_mul_div_if;
    import alu_mul_div_pkg::*;

    logic                    in_valid;
    Alu_Func_T               func;
    logic [ALU_MD_WIDTH-1:0] a;
    logic [ALU_MD_WIDTH-1:0] b;
    logic                    abort;
    logic                    in_ready;
    logic                    busy;
    logic [ALU_MD_WIDTH-1:0] rd_data;
    logic [ALU_MD_WIDTH-1:0] hi;
    logic [ALU_MD_WIDTH-1:0] lo;

    modport master (
        output in_valid, func, a, b, abort,
        input  in_ready, busy, rd_data, hi, lo
    );

    modport slave (
        input  in_valid, func, a, b, abort,
        output in_ready, busy, rd_data, hi, lo
    );

endinterface

// File: rtl/alu_mul_div_step.sv
// One iteration of the mul/div datapath: shift-add for multiply, restoring shift-subtract for divide.
module alu_mul_div_step
    import alu_mul_div_pkg::*;
(
    input  logic                        is_div,
    input  logic [ALU_MD_WIDTH-1:0]     operand,
    input  logic [2*ALU_MD_WIDTH-1:0]   acc,
    output logic [2*ALU_MD_WIDTH-1:0]   acc_next_c
);
    localparam int unsigned W = ALU_MD_WIDTH;

    logic [W:0]   mul_sum;
    logic [W:0]   rem_sh;
    logic         rem_ge;
    logic [W-1:0] rem_diff;

    // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});
        rem_sh   = {acc[2*W-1:W], acc[W-1]};
        rem_ge   = (rem_sh >= {1'b0, operand});
        // Difference fits W bits whenever rem_ge holds, since the old remainder was below the divisor.
        rem_diff = rem_sh[W-1:0] - operand;
        if (is_div) begin
            acc_next_c = rem_ge ? {rem_diff, acc[W-2:0], 1'b1}
                                : {rem_sh[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            acc_next_c = {mul_sum, acc[W-1:1]};
        end
    end

endmodule

// File: rtl/alu_mul_div.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
module alu_mul_div
    import alu_mul_div_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    alu_mul_div_if.slave bus
);
    localparam int unsigned W = ALU_MD_WIDTH;

    Alu_MulDiv_State_T     state;
    Alu_MulDiv_State_T     state_next;
    logic [ALU_MD_CNT_W-1:0] cnt;
    logic [2*W-1:0]        acc;
    logic [2*W-1:0]        acc_next_c;
    logic [W-1:0]          operand;
    Alu_MulDiv_Op_T        op;
    logic [W-1:0]          hi_q;
    logic [W-1:0]          lo_q;
    logic                  busy_q;

    logic                  accept_c;
    logic                  start_c;
    logic                  start_signed_c;
    logic [W-1:0]          a_mag_c;
    logic [W-1:0]          b_mag_c;
    logic [2*W-1:0]        prod_c;
    logic [W-1:0]          quot_c;
    logic [W-1:0]          rem_c;

    alu_mul_div_step u_step (
        .is_div     (op.is_div),
        .operand    (operand),
        .acc        (acc),
        .acc_next_c (acc_next_c)
    );

    // Accept decode and operand magnitudes for a new op.
    always_comb begin
        accept_c       = bus.in_valid & ~bus.abort & (state == Alu_MulDiv_State_Idle);
        start_c        = accept_c & is_muldiv_op(bus.func);
        start_signed_c = (bus.func == Alu_Func_Muls) || (bus.func == Alu_Func_Divs);
        a_mag_c        = (start_signed_c && bus.a[W-1]) ? -bus.a : bus.a;
        b_mag_c        = (start_signed_c && bus.b[W-1]) ? -bus.b : bus.b;
    end

    // Sign fix-up of the finished accumulator.
    always_comb begin
        prod_c = acc;
        quot_c = acc[W-1:0];
        rem_c  = acc[2*W-1:W];
        if (op.is_signed && (op.a_neg ^ op.b_neg)) begin
            prod_c = -acc;
            quot_c = -acc[W-1:0];
        end
        if (op.is_signed && op.a_neg) begin
            rem_c = -acc[2*W-1:W];
        end
        // The remainder already equals the latched dividend on a zero divisor; only the quotient needs forcing.
        if (operand == '0) begin
            quot_c = ALU_MD_DIV0_QUOTIENT;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= Alu_MulDiv_State_Idle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            Alu_MulDiv_State_Idle: begin
                if (start_c) state_next = Alu_MulDiv_State_Run;
            end
            Alu_MulDiv_State_Run: begin
                if (bus.abort) begin
                    state_next = Alu_MulDiv_State_Idle;
                end else if (cnt == ALU_MD_CNT_W'(W - 1)) begin
                    state_next = Alu_MulDiv_State_Fix;
                end
            end
            Alu_MulDiv_State_Fix: begin
                state_next = Alu_MulDiv_State_Idle;
            end
            default: begin
                state_next = Alu_MulDiv_State_Idle;
            end
        endcase
    end

    // Datapath registers, iteration counter and HI/LO.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            op      <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_next != Alu_MulDiv_State_Idle);
            if (start_c) begin
                op.is_div    <= (bus.func == Alu_Func_Divs) || (bus.func == Alu_Func_Divu);
                op.is_signed <= start_signed_c;
                op.a_neg     <= start_signed_c & bus.a[W-1];
                op.b_neg     <= start_signed_c & bus.b[W-1];
                cnt          <= '0;
                if ((bus.func == Alu_Func_Divs) || (bus.func == Alu_Func_Divu)) begin
                    acc     <= {{W{1'b0}}, a_mag_c};
                    operand <= b_mag_c;
                end else begin
                    acc     <= {{W{1'b0}}, b_mag_c};
                    operand <= a_mag_c;
                end
            end else if (state == Alu_MulDiv_State_Run) begin
                acc <= acc_next_c;
                cnt <= cnt + ALU_MD_CNT_W'(1);
            end

            if ((state == Alu_MulDiv_State_Fix) && !bus.abort) begin
                if (op.is_div) begin
                    hi_q <= rem_c;
                    lo_q <= quot_c;
                end else begin
                    hi_q <= prod_c[2*W-1:W];
                    lo_q <= prod_c[W-1:0];
                end
            end else if (accept_c && (bus.func == Alu_Func_Mthi)) begin
                hi_q <= bus.a;
            end else if (accept_c && (bus.func == Alu_Func_Mtlo)) begin
                lo_q <= bus.a;
            end
        end
    end

    // Handshake and read-back outputs.
    assign bus.in_ready = ~(busy_q & is_hilo_op(bus.func));
    assign bus.busy     = busy_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.rd_data  = (bus.func == Alu_Func_Mfhi) ? hi_q :
                          (bus.func == Alu_Func_Mflo) ? lo_q : '0;

endmodule

// File: tb/tb_alu_mul_div.sv
// Scoreboard bench for alu_mul_div: stimulus queues expected HI/LO or rd_data, monitor compares.
module tb_alu_mul_div;
    import alu_mul_div_pkg::*;

    localparam int KIND_HILO = 1;
    localparam int KIND_RD   = 2;

    typedef struct {
        int          kind;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    alu_mul_div_if bus ();

    alu_mul_div dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one op and hold it until accepted; optionally queue its expected outcome.
    task automatic op(input Alu_Func_T f, input logic [31:0] av, input logic [31:0] bv,
                      input int kind, input logic [31:0] eh, input logic [31:0] el,
                      input string name, output int stalls);
        exp_t e;
        if (kind != 0) begin
            e.kind = kind; e.hi = eh; e.lo = el; e.name = name;
            sb.push_back(e);
        end
        bus.in_valid = 1'b1; bus.func = f; bus.a = av; bus.b = bv;
        stalls = 0;
        forever begin
            @(negedge clock);
            if (bus.in_ready === 1'b1) break;
            stalls++;
            if (stalls > 200) begin
                n_tests++; n_fail++;
                $display("FAIL %s_accept: got stalled 200 cycles expected acceptance", name);
                break;
            end
        end
        @(posedge clock); #1;
        bus.in_valid = 1'b0; bus.func = Alu_Func_Add; bus.a = '0; bus.b = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        forever begin
            @(negedge clock);
            if (bus.busy === 1'b0) break;
            n++;
            if (n > 100) begin
                n_tests++; n_fail++;
                $display("FAIL %s_idle: got busy 100 cycles expected idle", name);
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    // Monitor: HI/LO checked when busy falls, rd_data checked when Mfhi/Mflo is accepted.
    initial begin : monitor
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (prev_busy && (bus.busy === 1'b0)) begin
                if (sb.size() == 0 || sb[0].kind != KIND_HILO) begin
                    n_tests++; n_fail++;
                    $display("FAIL done_event: got op completion expected no completion pending");
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, bus.hi, e.hi);
                    check({e.name, "_lo"}, bus.lo, e.lo);
                end
            end
            if ((bus.in_valid === 1'b1) && (bus.in_ready === 1'b1) && (bus.abort === 1'b0) &&
                (reset === 1'b0) && ((bus.func == Alu_Func_Mfhi) || (bus.func == Alu_Func_Mflo))) begin
                if (sb.size() == 0 || sb[0].kind != KIND_RD) begin
                    n_tests++; n_fail++;
                    $display("FAIL rd_event: got read accept expected no read pending");
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_rd"}, bus.rd_data, e.hi);
                end
            end
            prev_busy = (bus.busy === 1'b1);
        end
    end

    initial begin : stim
        int s;
        int nb;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.func = Alu_Func_Add; bus.a = '0; bus.b = '0; bus.abort = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_rd_data", bus.rd_data, 32'd0);
        @(posedge clock); #1;

        // Unsigned max*max, busy duration.
        op(Alu_Func_Mulu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, KIND_HILO, 32'hFFFF_FFFE, 32'h0000_0001, "mulu_max", s);
        nb = 0;
        forever begin
            @(negedge clock);
            if (bus.busy !== 1'b1) break;
            nb++;
            if (nb > 100) break;
        end
        check("mulu_busy_cycles", 32'(nb), 32'd33);
        @(posedge clock); #1;

        // Signed -3*5 with Mflo stalled behind it, accepted in the first idle cycle.
        op(Alu_Func_Muls, 32'hFFFF_FFFD, 32'd5, KIND_HILO, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "muls_neg", s);
        op(Alu_Func_Mflo, 32'd0, 32'd0, KIND_RD, 32'hFFFF_FFF1, 32'd0, "mflo_after_muls", s);
        check("mflo_stall_cycles", 32'(s), 32'd33);

        op(Alu_Func_Divs, 32'hFFFF_FFF9, 32'd2, KIND_HILO, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divs_m7_2", s);
        op(Alu_Func_Mfhi, 32'd0, 32'd0, KIND_RD, 32'hFFFF_FFFF, 32'd0, "mfhi_after_divs", s);

        op(Alu_Func_Divs, 32'h8000_0000, 32'hFFFF_FFFF, KIND_HILO, 32'h0, 32'h8000_0000, "divs_ovf", s);
        wait_idle("divs_ovf");
        op(Alu_Func_Divu, 32'd7, 32'd0, KIND_HILO, 32'd7, 32'hFFFF_FFFF, "divu_by0", s);
        wait_idle("divu_by0");
        op(Alu_Func_Divs, 32'hFFFF_FFFB, 32'd0, KIND_HILO, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "divs_by0", s);
        wait_idle("divs_by0");
        op(Alu_Func_Divu, 32'd100, 32'd7, KIND_HILO, 32'd2, 32'd14, "divu_100_7", s);
        wait_idle("divu_100_7");

        // Mthi then Mfhi next cycle.
        op(Alu_Func_Mthi, 32'h1234, 32'd0, 0, 32'd0, 32'd0, "mthi", s);
        op(Alu_Func_Mfhi, 32'd0, 32'd0, KIND_RD, 32'h1234, 32'd0, "mfhi_after_mthi", s);

        // Abort mid-run leaves HI/LO untouched.
        op(Alu_Func_Muls, 32'd7, 32'd9, KIND_HILO, 32'h1234, 32'd14, "muls_abort", s);
        repeat (9) @(posedge clock);
        #1 bus.abort = 1'b1;
        @(posedge clock); #1 bus.abort = 1'b0;
        @(negedge clock);
        check("abort_busy", 32'(bus.busy), 32'd0);
        @(posedge clock); #1;

        // Abort beats a valid Mtlo in IDLE.
        bus.in_valid = 1'b1; bus.func = Alu_Func_Mtlo; bus.a = 32'h5555; bus.abort = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0; bus.func = Alu_Func_Add; bus.a = '0; bus.abort = 1'b0;
        op(Alu_Func_Mflo, 32'd0, 32'd0, KIND_RD, 32'd14, 32'd0, "mflo_after_idle_abort", s);

        // Non-HI/LO func during busy never stalls.
        op(Alu_Func_Mulu, 32'd3, 32'd4, KIND_HILO, 32'd0, 32'd12, "mulu_3_4", s);
        bus.in_valid = 1'b1; bus.func = Alu_Func_Add; bus.a = 32'hDEAD; bus.b = 32'hBEEF;
        @(negedge clock);
        check("add_in_ready_busy", 32'(bus.in_ready), 32'd1);
        check("add_busy_kept", 32'(bus.busy), 32'd1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        wait_idle("mulu_3_4");

        // Back-to-back: second mul waits for the first to retire.
        op(Alu_Func_Mulu, 32'd2, 32'd3, KIND_HILO, 32'd0, 32'd6, "mulu_2_3", s);
        op(Alu_Func_Mulu, 32'h0001_0000, 32'h0001_0000, KIND_HILO, 32'd1, 32'd0, "mulu_2p32", s);
        check("b2b_stall_cycles", 32'(s), 32'd33);
        wait_idle("mulu_2p32");

        // Reset mid-run clears everything.
        op(Alu_Func_Mulu, 32'd5, 32'd5, KIND_HILO, 32'd0, 32'd0, "reset_mid_run", s);
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_hi", bus.hi, 32'd0);
        check("rst_mid_lo", bus.lo, 32'd0);

        repeat (3) @(posedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
